button_debouncer: RTL and testbench

- Front end for raw PMOD push-buttons.
- Synchronises each button input into the clk domain and filters contact bounce.
- Produces a clean pressed level plus single-cycle press and release strobes per button.
- Counter/LED blocks consume these strobes as clean clock-enable events instead of clocking logic directly from a button.

---
 rtl/button_debouncer_if.sv | 32 +++
 rtl/button_debouncer.sv | 85 ++++++++
 tb/tb_button_debouncer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/button_debouncer_if.sv
`default_nettype none
// ============================================================================
// Module   : button_debouncer_if
// Brief    : Raw button pins in, clean level and press/release strobes out.
// Revision : 1.0 - initial release
// ============================================================================
interface button_debouncer_if #(
    parameter int NUM_BTN = 4
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic               any_press;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  any_press
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output any_press
    );
endinterface
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : button_debouncer
// Brief    : Per-button two-flop synchroniser, stable-count debounce filter,
//            and registered one-cycle press/release strobes.
// Revision : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter int          NUM_BTN         = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 240000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    button_debouncer_if.slave btn_if
);

    localparam int                 c_CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [NUM_BTN-1:0] c_POL     = {NUM_BTN{ACTIVE_LOW}};

    logic [NUM_BTN-1:0] w_norm;
    logic [NUM_BTN-1:0] w_diff;
    logic [NUM_BTN-1:0] w_fire;
    logic [NUM_BTN-1:0] r_sync1;
    logic [NUM_BTN-1:0] r_sync2;
    logic [NUM_BTN-1:0] r_level;
    logic [NUM_BTN-1:0] r_press;
    logic [NUM_BTN-1:0] r_release;
    logic               r_any_press;

    // After normalisation 1 always means pressed, whatever the pin polarity.
    assign w_norm = btn_if.btn_raw ^ c_POL;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_norm;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
        logic [c_CNT_W-1:0] r_cnt;

        assign w_diff[gi] = r_sync2[gi] ^ r_level[gi];
        assign w_fire[gi] = w_diff[gi] && (r_cnt == c_CNT_MAX);

        // Any agreeing sample restarts the count; reaching the limit accepts
        // the new level and restarts too, so the count never passes c_CNT_MAX.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (!w_diff[gi] || w_fire[gi]) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level     <= '0;
            r_press     <= '0;
            r_release   <= '0;
            r_any_press <= 1'b0;
        end else begin
            r_level     <= r_level ^ w_fire;
            r_press     <= w_fire & r_sync2;
            r_release   <= w_fire & ~r_sync2;
            r_any_press <= |(w_fire & r_sync2);
        end
    end

    assign btn_if.btn_level   = r_level;
    assign btn_if.btn_press   = r_press;
    assign btn_if.btn_release = r_release;
    assign btn_if.any_press   = r_any_press;

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_button_debouncer
// Brief    : Directed vector table plus random stimulus against a window model,
//            on an active-low and an active-high instance driven with mirrored pins.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

    localparam int NB = 4;
    localparam int DC = 4;

    typedef struct {
        logic          rst;
        logic [NB-1:0] raw;
        logic [NB-1:0] lvl;
        logic [NB-1:0] prs;
        logic [NB-1:0] rel;
        logic          any;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    vec_t vecs[$];

    // Model state: n is the pressed=1 view of the pins.
    logic [NB-1:0] m_s1  = '0;
    logic [NB-1:0] m_s2  = '0;
    logic [NB-1:0] m_lvl = '0;
    logic [NB-1:0] m_prs = '0;
    logic [NB-1:0] m_rel = '0;
    logic          m_any = 1'b0;
    logic [NB-1:0] m_obs[$];

    always #5 clk = ~clk;

    button_debouncer_if #(.NUM_BTN(NB)) bif0 ();
    button_debouncer_if #(.NUM_BTN(NB)) bif1 ();

    button_debouncer #(
        .NUM_BTN(NB), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1'b1)
    ) dut0 (
        .clk(clk), .rst(rst), .btn_if(bif0.slave)
    );

    button_debouncer #(
        .NUM_BTN(NB), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1'b0)
    ) dut1 (
        .clk(clk), .rst(rst), .btn_if(bif1.slave)
    );

    task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [NB-1:0] raw, input logic [NB-1:0] lvl,
                       input logic [NB-1:0] prs, input logic [NB-1:0] rel);
        vec_t v;
        v.rst = r; v.raw = raw; v.lvl = lvl; v.prs = prs; v.rel = rel; v.any = |prs;
        vecs.push_back(v);
    endtask

    task automatic add_hold(input logic r, input logic [NB-1:0] raw, input logic [NB-1:0] lvl, input int n);
        for (int k = 0; k < n; k++) add(r, raw, lvl, '0, '0);
    endtask

    // Pins settle at the first record; the event lands on record DC+2.
    task automatic settle(input logic [NB-1:0] raw, input logic [NB-1:0] old_lvl,
                          input logic [NB-1:0] new_lvl, input int n);
        add_hold(1'b0, raw, old_lvl, DC + 1);
        add(1'b0, raw, new_lvl, new_lvl & ~old_lvl, old_lvl & ~new_lvl);
        add_hold(1'b0, raw, new_lvl, n - DC - 2);
    endtask

    // Level flips once the last DC synchronised samples all disagree with it.
    task automatic model_step(input logic r, input logic [NB-1:0] raw);
        logic all_diff;
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prs = '0; m_rel = '0; m_any = 1'b0;
            m_obs.delete();
        end else begin
            m_obs.push_back(m_s2);
            if (m_obs.size() > DC) void'(m_obs.pop_front());
            m_s2 = m_s1;
            m_s1 = ~raw;
            m_prs = '0;
            m_rel = '0;
            for (int b = 0; b < NB; b++) begin
                all_diff = (m_obs.size() == DC);
                for (int j = 0; j < m_obs.size(); j++)
                    if (m_obs[j][b] == m_lvl[b]) all_diff = 1'b0;
                if (all_diff) begin
                    m_lvl[b] = ~m_lvl[b];
                    if (m_lvl[b]) m_prs[b] = 1'b1;
                    else          m_rel[b] = 1'b1;
                end
            end
            m_any = |m_prs;
        end
    endtask

    task automatic check_model();
        check("model_level_al",   bif0.btn_level,   m_lvl);
        check("model_press_al",   bif0.btn_press,   m_prs);
        check("model_release_al", bif0.btn_release, m_rel);
        check("model_any_al",     {{(NB-1){1'b0}}, bif0.any_press}, {{(NB-1){1'b0}}, m_any});
        check("model_level_ah",   bif1.btn_level,   m_lvl);
        check("model_press_ah",   bif1.btn_press,   m_prs);
        check("model_release_ah", bif1.btn_release, m_rel);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(rst, bif0.btn_raw);
        #1;
        check_model();
    endtask

    logic [NB-1:0] rnd_raw;
    int            hold_left[NB];

    initial begin
        bif0.btn_raw = '1;
        bif1.btn_raw = '0;

        add_hold(1'b1, 4'hF, 4'h0, 3);
        add_hold(1'b0, 4'hF, 4'h0, 4);
        // Clean press and release on bit 0.
        settle(4'hE, 4'h0, 4'h1, 20);
        settle(4'hF, 4'h1, 4'h0, 10);
        // Bit 1 bouncing every 2 cycles never qualifies.
        for (int k = 0; k < 15; k++) add_hold(1'b0, (k % 2 == 0) ? 4'hD : 4'hF, 4'h0, 2);
        add_hold(1'b0, 4'hF, 4'h0, 8);
        // Press then release on bit 2, strobes 10 cycles apart.
        settle(4'hB, 4'h0, 4'h4, 10);
        settle(4'hF, 4'h4, 4'h0, 10);
        // All four together.
        settle(4'h0, 4'h0, 4'hF, 10);
        settle(4'hF, 4'hF, 4'h0, 10);
        // Reset at count 2 while bit 0 is held; fresh press after release of rst.
        add_hold(1'b0, 4'hE, 4'h0, 4);
        add_hold(1'b1, 4'hE, 4'h0, 3);
        settle(4'hE, 4'h0, 4'h1, 10);
        settle(4'hF, 4'h1, 4'h0, 10);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst          = vecs[i].rst;
            bif0.btn_raw = vecs[i].raw;
            bif1.btn_raw = ~vecs[i].raw;
            tick();
            check("tab_level_al",   bif0.btn_level,   vecs[i].lvl);
            check("tab_press_al",   bif0.btn_press,   vecs[i].prs);
            check("tab_release_al", bif0.btn_release, vecs[i].rel);
            check("tab_any_al",     {{(NB-1){1'b0}}, bif0.any_press}, {{(NB-1){1'b0}}, vecs[i].any});
            check("tab_level_ah",   bif1.btn_level,   vecs[i].lvl);
            check("tab_press_ah",   bif1.btn_press,   vecs[i].prs);
            check("tab_release_ah", bif1.btn_release, vecs[i].rel);
            check("tab_any_ah",     {{(NB-1){1'b0}}, bif1.any_press}, {{(NB-1){1'b0}}, vecs[i].any});
        end

        rnd_raw = '1;
        for (int b = 0; b < NB; b++) hold_left[b] = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            for (int b = 0; b < NB; b++) begin
                if (hold_left[b] == 0) begin
                    rnd_raw[b]   = 1'($urandom_range(0, 1));
                    hold_left[b] = $urandom_range(1, 8);
                end else begin
                    hold_left[b]--;
                end
            end
            rst          = ($urandom_range(0, 299) == 0);
            bif0.btn_raw = rnd_raw;
            bif1.btn_raw = ~rnd_raw;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
